// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and constants for the memory bus responder
package mem_bus_pkg;
  localparam int DATA_W = 16;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } state_t;
endpackage

// File: rtl/mem_bus_ram.sv
// mem_bus_ram: single-port word RAM with synchronous write and combinational read
module mem_bus_ram
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4096,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
  assign rdata = mem[addr];
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: memory-side four-phase handshake responder with wait states and preload port
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DEPTH = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              RESET_N,
  input  logic              MREQ_N,
  input  logic              R_W_N,
  input  logic [ADDR_W-1:0] a_bus,
  input  logic [DATA_W-1:0] s_bus,
  output logic              ACK,
  output logic [DATA_W-1:0] m_bus,
  output logic              BUS_ERR,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIMIT = DEPTH[ADDR_W:0];
  localparam logic [3:0] WC = WAIT_CYCLES[3:0];
  state_t state, state_nx;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr_q;
  logic rw_q;
  logic [DATA_W-1:0] data_q, rd_data, ram_wdata;
  logic [AW-1:0] ram_addr;
  logic req, done, hit, ld_ok, ram_we;
  always_comb begin
    req = state == IDLE && !MREQ_N;
    done = state == DONE;
    hit = {1'b0, addr_q} < LIMIT;
    ld_ok = state == IDLE && MREQ_N && ld_en && {1'b0, ld_addr} < LIMIT;
    ram_we = done ? (rw_q == WRITE && hit) : ld_ok;
    ram_addr = done ? addr_q[AW-1:0] : ld_addr[AW-1:0];
    ram_wdata = done ? data_q : ld_data;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = MREQ_N ? IDLE : (WC == 4'd0 ? DONE : WAIT);
      WAIT:    state_nx = MREQ_N ? IDLE : (cnt == 4'd1 ? DONE : WAIT);
      DONE:    state_nx = RELEASE;
      RELEASE: state_nx = MREQ_N ? IDLE : RELEASE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      rw_q <= READ;
      data_q <= '0;
      ACK <= 1'b0;
      m_bus <= '0;
      BUS_ERR <= 1'b0;
    end else begin
      state <= state_nx;
      if (req) begin
        addr_q <= a_bus;
        rw_q <= R_W_N;
        data_q <= s_bus;
        cnt <= WC;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (done) begin
        ACK <= 1'b1;
        m_bus <= (rw_q == READ && hit) ? rd_data : '0;
        BUS_ERR <= !hit;
      end else if (state == RELEASE && MREQ_N) begin
        ACK <= 1'b0;
        m_bus <= '0;
        BUS_ERR <= 1'b0;
      end
    end
  end
  mem_bus_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(ram_wdata),
    .rdata(rd_data)
  );
endmodule
